// File: rtl/c2c_ring_link_ctrl.sv
// Chip-to-chip ring link controller: lock/train/ready bring-up sequencing,
// word-level round-robin onto the outbound lane and inbound word capture.
module c2c_ring_link_ctrl #(
    parameter int unsigned N_REQ         = 2,
    parameter int unsigned LOCK_STABLE   = 16,
    parameter int unsigned TRAIN_LEN     = 32,
    parameter int unsigned TRAIN_TIMEOUT = 1024,
    parameter logic [31:0] TRAIN_WORD    = 32'h7A5A_C3C3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  local_locked,
    input  logic                  lock_in,
    output logic                  lock_out,
    input  logic                  ready_in,
    output logic                  ready_out,
    input  logic [31:0]           ring_in,
    output logic [31:0]           ring_out,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [31*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rx_valid,
    output logic [30:0]           rx_data,
    output logic                  link_up,
    output logic [2:0]            state,
    output logic [7:0]            relink_cnt
);

    localparam int unsigned PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_MAX = (LOCK_STABLE > TRAIN_LEN) ? LOCK_STABLE : TRAIN_LEN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned TMO_W   = $clog2(TRAIN_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOCK  = 3'd1,
        S_TRAIN = 3'd2,
        S_READY = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [7:0]         relink_q, relink_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               lock_out_q, lock_out_d;
    logic               ready_out_q, ready_out_d;
    logic               link_up_q, link_up_d;
    logic [31:0]        ring_out_q, ring_out_d;
    logic               rx_valid_q, rx_valid_d;
    logic [30:0]        rx_data_q, rx_data_d;

    logic               fault_c;
    logic               fault_idle_c;
    logic               relink_inc_c;
    logic               accept_c;
    logic               grant_any_c;
    logic [PTR_W-1:0]   grant_idx_c;
    logic [PTR_W-1:0]   cand_c;
    logic [30:0]        payload_c;

    // Link fault detection; losing the local clock outranks partner loss
    always_comb begin
        fault_c      = 1'b0;
        fault_idle_c = 1'b0;
        if (state_q != S_IDLE) begin
            if (!local_locked) begin
                fault_c      = 1'b1;
                fault_idle_c = 1'b1;
            end else if (state_q != S_LOCK &&
                         (!lock_in || (state_q == S_RUN && !ready_in))) begin
                fault_c = 1'b1;
            end
        end
    end

    // Round-robin search starting one past the last granted requester
    always_comb begin
        grant_any_c = 1'b0;
        grant_idx_c = ptr_q;
        cand_c      = ptr_q;
        payload_c   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand_c = PTR_W'((32'(ptr_q) + k) % N_REQ);
            if (!grant_any_c && req_valid[cand_c]) begin
                grant_any_c = 1'b1;
                grant_idx_c = cand_c;
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_idx_c == PTR_W'(i)) begin
                payload_c = req_data[31*i +: 31];
            end
        end
    end

    assign accept_c = (state_q == S_RUN) && !fault_c && grant_any_c;

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ready[i] = accept_c && (grant_idx_c == PTR_W'(i));
        end
    end

    // Next state, counters and registered output values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        relink_inc_c = 1'b0;
        if (fault_c) begin
            state_d      = fault_idle_c ? S_IDLE : S_LOCK;
            relink_inc_c = (state_q != S_LOCK);
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (local_locked) state_d = S_LOCK;
                end
                S_LOCK: begin
                    if (!lock_in) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
                        state_d = S_TRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_TRAIN: begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (ring_in != TRAIN_WORD) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_W'(TRAIN_LEN - 1)) begin
                        state_d = S_READY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (state_d == S_TRAIN && tmo_q == TMO_W'(TRAIN_TIMEOUT - 1)) begin
                        state_d      = S_LOCK;
                        relink_inc_c = 1'b1;
                    end
                end
                S_READY: begin
                    if (ready_in) state_d = S_RUN;
                end
                S_RUN: begin
                    state_d = S_RUN;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        if (state_d != state_q) begin
            cnt_d = '0;
            tmo_d = '0;
        end

        relink_d = (relink_inc_c && relink_q != 8'hFF) ? relink_q + 8'd1 : relink_q;
        ptr_d    = accept_c ? grant_idx_c : ptr_q;

        lock_out_d  = (state_d != S_IDLE);
        ready_out_d = (state_d == S_READY) || (state_d == S_RUN);
        link_up_d   = (state_d == S_RUN);
        unique case (state_d)
            S_TRAIN, S_READY: ring_out_d = TRAIN_WORD;
            S_RUN:            ring_out_d = accept_c ? {1'b1, payload_c} : 32'h0;
            default:          ring_out_d = 32'h0;
        endcase
        rx_valid_d = (state_d == S_RUN) ? ring_in[31]   : 1'b0;
        rx_data_d  = (state_d == S_RUN) ? ring_in[30:0] : rx_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            relink_q    <= '0;
            ptr_q       <= PTR_W'(N_REQ - 1);
            lock_out_q  <= 1'b0;
            ready_out_q <= 1'b0;
            link_up_q   <= 1'b0;
            ring_out_q  <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            relink_q    <= relink_d;
            ptr_q       <= ptr_d;
            lock_out_q  <= lock_out_d;
            ready_out_q <= ready_out_d;
            link_up_q   <= link_up_d;
            ring_out_q  <= ring_out_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
        end
    end

    assign lock_out   = lock_out_q;
    assign ready_out  = ready_out_q;
    assign link_up    = link_up_q;
    assign ring_out   = ring_out_q;
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign state      = state_q;
    assign relink_cnt = relink_q;

endmodule

// File: tb/tb_c2c_ring_link_ctrl.sv
// Two cross-connected link controllers: bring-up, arbitration against a
// round-robin reference model, faults, mid-run reset and training timeout.
module tb_c2c_ring_link_ctrl;

    localparam int unsigned N_REQ = 2;
    localparam int unsigned DW    = 31 * N_REQ;
    localparam logic [31:0] TW    = 32'h7A5A_C3C3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          loc_a, loc_b;
    logic          lock_en_a;
    logic          zero_rx_a;

    logic          lock_in_a, lock_out_a, ready_in_a, ready_out_a;
    logic [31:0]   ring_in_a, ring_out_a;
    logic [1:0]    req_valid_a, req_ready_a;
    logic [DW-1:0] req_data_a;
    logic          rx_valid_a, link_up_a;
    logic [30:0]   rx_data_a;
    logic [2:0]    state_a;
    logic [7:0]    relink_a;

    logic          lock_in_b, lock_out_b, ready_in_b, ready_out_b;
    logic [31:0]   ring_in_b, ring_out_b;
    logic [1:0]    req_valid_b, req_ready_b;
    logic [DW-1:0] req_data_b;
    logic          rx_valid_b, link_up_b;
    logic [30:0]   rx_data_b;
    logic [2:0]    state_b;
    logic [7:0]    relink_b;

    // Ring wiring, with hooks to break A's lock sideband or zero its inbound lane
    assign lock_in_a  = lock_out_b & lock_en_a;
    assign lock_in_b  = lock_out_a;
    assign ready_in_a = ready_out_b;
    assign ready_in_b = ready_out_a;
    assign ring_in_a  = zero_rx_a ? 32'h0 : ring_out_b;
    assign ring_in_b  = ring_out_a;

    c2c_ring_link_ctrl #(
        .N_REQ(N_REQ), .LOCK_STABLE(4), .TRAIN_LEN(8), .TRAIN_TIMEOUT(64), .TRAIN_WORD(TW)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .local_locked(loc_a),
        .lock_in(lock_in_a), .lock_out(lock_out_a),
        .ready_in(ready_in_a), .ready_out(ready_out_a),
        .ring_in(ring_in_a), .ring_out(ring_out_a),
        .req_valid(req_valid_a), .req_data(req_data_a), .req_ready(req_ready_a),
        .rx_valid(rx_valid_a), .rx_data(rx_data_a),
        .link_up(link_up_a), .state(state_a), .relink_cnt(relink_a)
    );

    c2c_ring_link_ctrl #(
        .N_REQ(N_REQ), .LOCK_STABLE(4), .TRAIN_LEN(8), .TRAIN_TIMEOUT(64), .TRAIN_WORD(TW)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .local_locked(loc_b),
        .lock_in(lock_in_b), .lock_out(lock_out_b),
        .ready_in(ready_in_b), .ready_out(ready_out_b),
        .ring_in(ring_in_b), .ring_out(ring_out_b),
        .req_valid(req_valid_b), .req_data(req_data_b), .req_ready(req_ready_b),
        .rx_valid(rx_valid_b), .rx_data(rx_data_b),
        .link_up(link_up_b), .state(state_b), .relink_cnt(relink_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: last granted requester, A's next outbound word, B's next capture
    int          ptr_m;
    logic [31:0] exp_tx;
    logic [31:0] rx_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a_state(input logic [2:0] s, input int budget, input string tag);
        int c = 0;
        while (state_a !== s && c < budget) begin
            step();
            c++;
        end
        chk(tag, 32'(state_a), 32'(s));
    endtask

    task automatic wait_both_run(input int budget, input string tag);
        int c = 0;
        while (!(state_a === 3'd4 && state_b === 3'd4) && c < budget) begin
            step();
            c++;
        end
        chk({tag, "_a"}, 32'(state_a), 4);
        chk({tag, "_b"}, 32'(state_b), 4);
    endtask

    // Let both lanes go quiet so the model can restart from an all-zero view
    task automatic sync_idle();
        req_valid_a = '0;
        for (int c = 0; c < 4; c++) step();
        exp_tx = '0;
        rx_exp = '0;
    endtask

    // One RUN cycle on A: check last edge's outputs, offer v/d, check grant, advance
    task automatic run_cycle(input logic [1:0] v, input logic [DW-1:0] d, output int g);
        logic [DW-1:0] sh;
        logic [1:0]    exp_rdy;
        chk("a_ring_out", ring_out_a, exp_tx);
        chk("b_rx_valid", 32'(rx_valid_b), 32'(rx_exp[31]));
        chk("b_rx_data", 32'(rx_data_b), 32'(rx_exp[30:0]));
        chk("a_rx_valid", 32'(rx_valid_a), 0);
        req_valid_a = v;
        req_data_a  = d;
        #1;
        g = -1;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            int i;
            i = (ptr_m + k) % int'(N_REQ);
            if (g < 0 && v[i]) g = i;
        end
        exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
        chk("a_req_ready", 32'(req_ready_a), 32'(exp_rdy));
        rx_exp = exp_tx;
        if (g >= 0) begin
            ptr_m  = g;
            sh     = d >> (31 * g);
            exp_tx = {1'b1, sh[30:0]};
        end else begin
            exp_tx = '0;
        end
        step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    v;
        logic [DW-1:0] d;
        int            g;
        int            n;
        int            exits;
        logic [2:0]    prev;

        rst_n = 1'b0; loc_a = 1'b0; loc_b = 1'b0;
        lock_en_a = 1'b1; zero_rx_a = 1'b0;
        req_valid_a = '0; req_data_a = '0;
        req_valid_b = '0; req_data_b = '0;
        ptr_m = N_REQ - 1; exp_tx = '0; rx_exp = '0;
        step(); step();

        chk("rst_state", 32'(state_a), 0);
        chk("rst_lock_out", 32'(lock_out_a), 0);
        chk("rst_ready_out", 32'(ready_out_a), 0);
        chk("rst_link_up", 32'(link_up_a), 0);
        chk("rst_ring_out", ring_out_a, 0);
        chk("rst_rx_data", 32'(rx_data_a), 0);
        chk("rst_relink", 32'(relink_a), 0);

        // Bring-up: local clocks come good at cycle 10
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) step();
        chk("idle_hold", 32'(state_a), 0);
        chk("idle_ring_out", ring_out_a, 0);
        loc_a = 1'b1; loc_b = 1'b1;
        wait_a_state(3'd1, 10, "reach_lock");
        chk("lock_lock_out", 32'(lock_out_a), 1);
        chk("lock_ring_out", ring_out_a, 0);
        wait_a_state(3'd2, 20, "reach_train");
        chk("train_lock_out", 32'(lock_out_a), 1);
        chk("train_ring_out_a", ring_out_a, TW);
        chk("train_ring_out_b", ring_out_b, TW);
        wait_both_run(100, "bringup_run");
        chk("bringup_link_a", 32'(link_up_a), 1);
        chk("bringup_link_b", 32'(link_up_b), 1);
        chk("bringup_relink_a", 32'(relink_a), 0);
        chk("bringup_relink_b", 32'(relink_b), 0);
        sync_idle();

        // Contended fairness, then a lone requester, then idle lane
        for (int c = 0; c < 8; c++) run_cycle(2'b11, {31'h2, 31'h1}, g);
        for (int c = 0; c < 8; c++) run_cycle(2'b10, {31'h1234_5678, 31'h0}, g);
        for (int c = 0; c < 3; c++) run_cycle(2'b00, '0, g);

        // Randomized requesters that hold their word until accepted
        v = '0; d = '0; g = -1;
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (!v[i] || g == i) begin
                    v[i]             = 1'($urandom_range(0, 1));
                    d[31*i +: 31]    = 31'($urandom);
                end
            end
            run_cycle(v, d, g);
        end
        for (int c = 0; c < 3; c++) run_cycle(2'b00, '0, g);

        // Single-cycle lock loss on A while both requesters are waiting
        req_valid_a = 2'b11;
        lock_en_a   = 1'b0;
        #1;
        chk("fault_no_accept", 32'(req_ready_a), 0);
        step();
        lock_en_a = 1'b1;
        chk("fault_state_a", 32'(state_a), 1);
        chk("fault_link_a", 32'(link_up_a), 0);
        chk("fault_ready_out_a", 32'(ready_out_a), 0);
        chk("fault_ring_out_a", ring_out_a, 0);
        chk("fault_relink_a", 32'(relink_a), 1);
        req_valid_a = '0;
        step();
        chk("fault_state_b", 32'(state_b), 1);
        chk("fault_relink_b", 32'(relink_b), 1);
        wait_both_run(200, "relink_run");
        chk("relink_link_a", 32'(link_up_a), 1);
        chk("relink_cnt_a", 32'(relink_a), 1);
        chk("relink_cnt_b", 32'(relink_b), 1);
        sync_idle();
        v = '0; d = '0; g = -1;
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (!v[i] || g == i) begin
                    v[i]          = 1'($urandom_range(0, 1));
                    d[31*i +: 31] = 31'($urandom);
                end
            end
            run_cycle(v, d, g);
        end
        for (int c = 0; c < 3; c++) run_cycle(2'b00, '0, g);

        // Leave requester 0 as last granted, then reset mid-run
        run_cycle(2'b01, {31'h0, 31'h55}, g);
        rst_n       = 1'b0;
        req_valid_a = 2'b11;
        step();
        rst_n       = 1'b1;
        req_valid_a = '0;
        chk("mrst_state_a", 32'(state_a), 0);
        chk("mrst_state_b", 32'(state_b), 0);
        chk("mrst_link_a", 32'(link_up_a), 0);
        chk("mrst_lock_out_a", 32'(lock_out_a), 0);
        chk("mrst_ready_out_a", 32'(ready_out_a), 0);
        chk("mrst_ring_out_a", ring_out_a, 0);
        chk("mrst_rx_valid_b", 32'(rx_valid_b), 0);
        chk("mrst_rx_data_b", 32'(rx_data_b), 0);
        chk("mrst_relink_a", 32'(relink_a), 0);
        chk("mrst_relink_b", 32'(relink_b), 0);
        ptr_m = N_REQ - 1;
        wait_both_run(100, "mrst_run");
        sync_idle();
        req_valid_a = 2'b11;
        req_data_a  = {31'h2, 31'h1};
        #1;
        chk("mrst_first_grant", 32'(req_ready_a), 1);
        for (int c = 0; c < 4; c++) run_cycle(2'b11, {31'h2, 31'h1}, g);
        for (int c = 0; c < 3; c++) run_cycle(2'b00, '0, g);

        // Training timeout with A's inbound lane stuck at zero
        rst_n = 1'b0; loc_a = 1'b0; loc_b = 1'b0; zero_rx_a = 1'b1;
        step();
        rst_n = 1'b1; loc_a = 1'b1; loc_b = 1'b1;
        wait_a_state(3'd2, 20, "tmo_reach_train");
        n = 0;
        while (state_a === 3'd2 && n < 200) begin
            step();
            n++;
        end
        chk("tmo_train_cycles", 32'(n), 64);
        chk("tmo_state", 32'(state_a), 1);
        chk("tmo_relink_1", 32'(relink_a), 1);
        exits = 1;
        prev  = state_a;
        for (int c = 0; c < 20000 && exits < 257; c++) begin
            step();
            if (prev === 3'd2 && state_a === 3'd1) begin
                exits++;
                chk("tmo_relink_sat", 32'(relink_a), 32'((exits > 255) ? 255 : exits));
            end
            prev = state_a;
        end
        chk("tmo_exits_seen", 32'(exits), 257);
        chk("tmo_partner_state", 32'(state_b), 3);
        chk("tmo_partner_relink", 32'(relink_b), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
